// File: rtl/tb_obi_mem_responder.sv
// rtl/tb_obi_mem_responder.sv - multi-port req/gnt/rvalid memory responder; TB_OBI_MEM_STALL_RAND_EN adds LFSR grant stalls
module tb_obi_mem_responder #(
  parameter int          N_PORTS     = 2,
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          GNT_LAT     = 0,
  parameter int          RVALID_LAT  = 1,
  parameter int          MAX_OUTST   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_PORTS-1:0]     req_i,
  input  logic [N_PORTS-1:0]     we_i,
  input  logic [4*N_PORTS-1:0]   be_i,
  input  logic [32*N_PORTS-1:0]  addr_i,
  input  logic [32*N_PORTS-1:0]  wdata_i,
  output logic [N_PORTS-1:0]     gnt_o,
  output logic [N_PORTS-1:0]     rvalid_o,
  output logic [32*N_PORTS-1:0]  rdata_o,
  output logic [N_PORTS-1:0]     err_o
);

  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int LAT_W  = $clog2(RVALID_LAT + 1);
  localparam int WAIT_W = $clog2(GNT_LAT + 1) + 1;
  localparam int OUT_W  = $clog2(MAX_OUTST + 1);
  localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  // Countdown of 0 means the entry may be issued in the current cycle.
  typedef struct packed {
    logic [31:0]      rdata;
    logic             err;
    logic [LAT_W-1:0] cnt;
  } entry_t;

  logic [31:0]      mem_q [DEPTH_WORDS];
  entry_t           q_q [N_PORTS][MAX_OUTST];
  entry_t           q_d [N_PORTS][MAX_OUTST];
  logic [PTR_W-1:0] rd_ptr_q [N_PORTS];
  logic [PTR_W-1:0] rd_ptr_d [N_PORTS];
  logic [PTR_W-1:0] wr_ptr_q [N_PORTS];
  logic [PTR_W-1:0] wr_ptr_d [N_PORTS];
  logic [OUT_W-1:0] outst_q [N_PORTS];
  logic [OUT_W-1:0] outst_d [N_PORTS];
  logic [OUT_W-1:0] outst_eff [N_PORTS];
  logic [WAIT_W-1:0] wait_q [N_PORTS];
  logic [WAIT_W-1:0] wait_d [N_PORTS];
  logic [31:0]      last_rdata_q [N_PORTS];
  logic [31:0]      last_rdata_d [N_PORTS];
  logic [N_PORTS-1:0] last_err_q, last_err_d;

  logic [31:0]        off [N_PORTS];
  logic [IDX_W-1:0]   idx [N_PORTS];
  logic [31:0]        rd_word [N_PORTS];
  entry_t             head [N_PORTS];
  logic [N_PORTS-1:0] in_range, gnt, rvalid, stall;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (int'(ptr) == MAX_OUTST - 1) ? '0 : ptr + PTR_W'(1);
  endfunction

`ifdef TB_OBI_MEM_STALL_RAND_EN
  logic [15:0] lfsr_q [N_PORTS];
  logic [15:0] lfsr_d [N_PORTS];

  // Galois LFSR x^16+x^14+x^13+x^11+1; lsb set steals the grant this cycle
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      lfsr_d[p] = {1'b0, lfsr_q[p][15:1]} ^ (lfsr_q[p][0] ? 16'hB400 : 16'h0000);
      stall[p]  = lfsr_q[p][0];
    end
  end

  // LFSR state, each port seeded differently so ports stall independently
  always_ff @(posedge clk_i or negedge rst_ni) begin
    for (int p = 0; p < N_PORTS; p++) begin
      if (!rst_ni) lfsr_q[p] <= 16'hACE1 + 16'(p);
      else         lfsr_q[p] <= lfsr_d[p];
    end
  end
`else
  // Deterministic grant timing: never stall
  always_comb stall = '0;
`endif

  // Address decode and pre-edge array read for every port
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      off[p]      = addr_i[32*p +: 32] - BASE_ADDR;
      in_range[p] = (addr_i[32*p +: 32] >= BASE_ADDR) && ((off[p] >> 2) < 32'(DEPTH_WORDS));
      idx[p]      = off[p][IDX_W+1:2];
      rd_word[p]  = (in_range[p] && !we_i[p]) ? mem_q[idx[p]] : 32'h0;
    end
  end

  // Grant, response queue and output selection per port
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      head[p]      = q_q[p][rd_ptr_q[p]];
      rvalid[p]    = (outst_q[p] != '0) && (head[p].cnt == '0);
      // A response retiring this cycle frees its slot for a same-cycle grant.
      outst_eff[p] = outst_q[p] - OUT_W'(rvalid[p]);
      gnt[p]       = rst_ni && req_i[p] && (int'(wait_q[p]) >= GNT_LAT) &&
                     (int'(outst_eff[p]) < MAX_OUTST) && !stall[p];

      if (req_i[p] && !gnt[p])
        wait_d[p] = (int'(wait_q[p]) < GNT_LAT) ? wait_q[p] + WAIT_W'(1) : wait_q[p];
      else
        wait_d[p] = '0;

      for (int e = 0; e < MAX_OUTST; e++) begin
        q_d[p][e] = q_q[p][e];
        if (q_q[p][e].cnt != '0) q_d[p][e].cnt = q_q[p][e].cnt - LAT_W'(1);
      end
      if (gnt[p]) begin
        q_d[p][wr_ptr_q[p]].rdata = rd_word[p];
        q_d[p][wr_ptr_q[p]].err   = !in_range[p];
        q_d[p][wr_ptr_q[p]].cnt   = LAT_W'(RVALID_LAT - 1);
      end

      wr_ptr_d[p] = gnt[p]    ? ptr_inc(wr_ptr_q[p]) : wr_ptr_q[p];
      rd_ptr_d[p] = rvalid[p] ? ptr_inc(rd_ptr_q[p]) : rd_ptr_q[p];
      outst_d[p]  = outst_eff[p] + OUT_W'(gnt[p]);

      last_rdata_d[p] = rvalid[p] ? head[p].rdata : last_rdata_q[p];
      last_err_d[p]   = rvalid[p] ? head[p].err   : last_err_q[p];

      gnt_o[p]            = gnt[p];
      rvalid_o[p]         = rvalid[p];
      err_o[p]            = last_err_d[p];
      rdata_o[32*p +: 32] = last_rdata_d[p];
    end
  end

  // Per-port state; reset drops every queued response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_err_q <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        for (int e = 0; e < MAX_OUTST; e++) q_q[p][e] <= '0;
        rd_ptr_q[p]     <= '0;
        wr_ptr_q[p]     <= '0;
        outst_q[p]      <= '0;
        wait_q[p]       <= '0;
        last_rdata_q[p] <= '0;
      end
    end else begin
      last_err_q <= last_err_d;
      for (int p = 0; p < N_PORTS; p++) begin
        for (int e = 0; e < MAX_OUTST; e++) q_q[p][e] <= q_d[p][e];
        rd_ptr_q[p]     <= rd_ptr_d[p];
        wr_ptr_q[p]     <= wr_ptr_d[p];
        outst_q[p]      <= outst_d[p];
        wait_q[p]       <= wait_d[p];
        last_rdata_q[p] <= last_rdata_d[p];
      end
    end
  end

  // Array writes at the grant edge; later ports override earlier ones per byte
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < N_PORTS; p++) begin
      if (gnt[p] && we_i[p] && in_range[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[4*p+b]) mem_q[idx[p]][8*b +: 8] <= wdata_i[32*p+8*b +: 8];
        end
      end
    end
  end

endmodule
